// File: rtl/estado_run_controller.sv
// rtl/estado_run_controller.sv - start/stop/step sequencer driving the state machine pause input
module estado_run_controller #(
    parameter int STEP_LEN = 4,
    parameter int RUN_MAX  = 0,
    parameter int CNT_W    = 16
) (
    input  logic             iClk,
    input  logic             iRestart,
    input  logic             iStart,
    input  logic             iStop,
    input  logic             iStep,
    input  logic             iTargetEn,
    input  logic [1:0]       iTargetState,
    input  logic [1:0]       iValorEstado,
    output logic             oPause,
    output logic             oBusy,
    output logic             oDone,
    output logic [CNT_W-1:0] oStepCount,
    output logic [1:0]       oRunState
);

    // A one-cycle step still needs a 1-bit counter holding 0.
    localparam int STEP_W = (STEP_LEN > 1) ? $clog2(STEP_LEN) : 1;
    localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEP_LEN - 1);
    localparam logic [CNT_W-1:0]  RUN_LIMIT = CNT_W'(RUN_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_HALT = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic                r_start_prev;
    logic                r_stop_prev;
    logic                r_step_prev;
    logic [1:0]          r_estado_prev;
    logic [STEP_W-1:0]   r_step_cnt;
    logic [STEP_W-1:0]   w_step_cnt_nx;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_nx;
    logic [CNT_W-1:0]    w_count_inc;
    logic                r_pause;
    logic                r_busy;
    logic                r_done;
    logic                w_done_nx;
    logic                w_start_ev;
    logic                w_stop_ev;
    logic                w_step_ev;
    logic                w_target_hit;
    logic                w_timeout;

    // Rising-edge detection; prev regs reset high so levels held across reset are ignored.
    assign w_start_ev = iStart & ~r_start_prev;
    assign w_stop_ev  = iStop  & ~r_stop_prev;
    assign w_step_ev  = iStep  & ~r_step_prev;

    // Only the transition into the target counts, so resuming from HALT does not re-halt.
    assign w_target_hit = iTargetEn && (iValorEstado == iTargetState)
                          && (r_estado_prev != iTargetState);

    // Active-cycle count, saturating at all ones.
    assign w_count_inc = (!r_pause && (r_count != {CNT_W{1'b1}})) ? r_count + 1'b1 : r_count;

    assign w_timeout = (RUN_MAX != 0) && (w_count_inc == RUN_LIMIT);

    // Next-state and next-output decode with priority stop > target > timeout/step end.
    always_comb begin
        w_state_nx    = r_state;
        w_step_cnt_nx = r_step_cnt;
        w_count_nx    = w_count_inc;
        w_done_nx     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_stop_ev) begin
                    w_state_nx = S_IDLE;
                end else if (w_start_ev) begin
                    w_state_nx = S_RUN;
                    w_count_nx = '0;
                end else if (w_step_ev) begin
                    w_state_nx    = S_STEP;
                    w_count_nx    = '0;
                    w_step_cnt_nx = STEP_LOAD;
                end
            end
            S_RUN: begin
                if (w_stop_ev) begin
                    w_state_nx = S_IDLE;
                end else if (w_target_hit) begin
                    w_state_nx = S_HALT;
                    w_done_nx  = 1'b1;
                end else if (w_timeout) begin
                    w_state_nx = S_IDLE;
                    w_done_nx  = 1'b1;
                end
            end
            S_STEP: begin
                if (w_stop_ev) begin
                    w_state_nx = S_IDLE;
                end else if (w_target_hit) begin
                    w_state_nx = S_HALT;
                    w_done_nx  = 1'b1;
                end else if (r_step_cnt == '0) begin
                    w_state_nx = S_IDLE;
                    w_done_nx  = 1'b1;
                end else begin
                    w_step_cnt_nx = r_step_cnt - 1'b1;
                end
            end
            default: begin
                if (w_stop_ev) begin
                    w_state_nx = S_IDLE;
                end else if (w_start_ev) begin
                    w_state_nx = S_RUN;
                end else if (w_step_ev) begin
                    w_state_nx    = S_STEP;
                    w_step_cnt_nx = STEP_LOAD;
                end
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge iClk or posedge iRestart) begin
        if (iRestart) begin
            r_state       <= S_IDLE;
            r_start_prev  <= 1'b1;
            r_stop_prev   <= 1'b1;
            r_step_prev   <= 1'b1;
            r_estado_prev <= 2'b00;
            r_step_cnt    <= '0;
            r_count       <= '0;
            r_pause       <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_start_prev  <= iStart;
            r_stop_prev   <= iStop;
            r_step_prev   <= iStep;
            r_estado_prev <= iValorEstado;
            r_step_cnt    <= w_step_cnt_nx;
            r_count       <= w_count_nx;
            r_pause       <= (w_state_nx == S_IDLE) || (w_state_nx == S_HALT);
            r_busy        <= (w_state_nx == S_RUN) || (w_state_nx == S_STEP);
            r_done        <= w_done_nx;
        end
    end

    assign oPause     = r_pause;
    assign oBusy      = r_busy;
    assign oDone      = r_done;
    assign oStepCount = r_count;
    assign oRunState  = r_state;

endmodule

// File: tb/tb_estado_run_controller.sv
// tb/tb_estado_run_controller.sv - directed self-checking bench for estado_run_controller
module tb_estado_run_controller;

    logic        iClk;
    logic        iRestart;
    logic        iStart;
    logic        iStop;
    logic        iStep;
    logic        iTargetEn;
    logic [1:0]  iTargetState;
    logic [1:0]  iValorEstado;

    logic        pause_m, busy_m, done_m;
    logic [15:0] cnt_m;
    logic [1:0]  st_m;
    logic        pause_t, busy_t, done_t;
    logic [15:0] cnt_t;
    logic [1:0]  st_t;
    logic        pause_s, busy_s, done_s;
    logic [3:0]  cnt_s;
    logic [1:0]  st_s;

    int n_cmp = 0;
    int n_err = 0;

    estado_run_controller #(.STEP_LEN(4), .RUN_MAX(0), .CNT_W(16)) dut (
        .iClk(iClk), .iRestart(iRestart), .iStart(iStart), .iStop(iStop), .iStep(iStep),
        .iTargetEn(iTargetEn), .iTargetState(iTargetState), .iValorEstado(iValorEstado),
        .oPause(pause_m), .oBusy(busy_m), .oDone(done_m), .oStepCount(cnt_m), .oRunState(st_m)
    );

    estado_run_controller #(.STEP_LEN(4), .RUN_MAX(20), .CNT_W(16)) dut_to (
        .iClk(iClk), .iRestart(iRestart), .iStart(iStart), .iStop(iStop), .iStep(iStep),
        .iTargetEn(iTargetEn), .iTargetState(iTargetState), .iValorEstado(iValorEstado),
        .oPause(pause_t), .oBusy(busy_t), .oDone(done_t), .oStepCount(cnt_t), .oRunState(st_t)
    );

    estado_run_controller #(.STEP_LEN(4), .RUN_MAX(0), .CNT_W(4)) dut_sat (
        .iClk(iClk), .iRestart(iRestart), .iStart(iStart), .iStop(iStop), .iStep(iStep),
        .iTargetEn(iTargetEn), .iTargetState(iTargetState), .iValorEstado(iValorEstado),
        .oPause(pause_s), .oBusy(busy_s), .oDone(done_s), .oStepCount(cnt_s), .oRunState(st_s)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        iRestart = 1'b1; iStart = 0; iStop = 0; iStep = 0;
        iTargetEn = 0; iTargetState = 2'b00; iValorEstado = 2'b00;
        tick(); tick();
        n_cmp++;
        if ({pause_m, busy_m, done_m, st_m} !== 5'b10000 || cnt_m !== 16'd0) begin
            n_err++;
            $display("FAIL reset_state got p/b/d/st=%b cnt=%0d exp 10000 cnt=0",
                     {pause_m, busy_m, done_m, st_m}, cnt_m);
        end
        iRestart = 1'b0;
        tick();
    endtask

    task automatic test_run();
        iStart = 1'b1; tick(); iStart = 1'b0;
        n_cmp++;
        if ({pause_m, busy_m, done_m, st_m} !== 5'b01001 || cnt_m !== 16'd0) begin
            n_err++;
            $display("FAIL run_entry got p/b/d/st=%b cnt=%0d exp 01001 cnt=0",
                     {pause_m, busy_m, done_m, st_m}, cnt_m);
        end
        repeat (10) tick();
        n_cmp++;
        if (cnt_m !== 16'd10 || st_m !== 2'b01) begin
            n_err++;
            $display("FAIL run_count10 got cnt=%0d st=%b exp cnt=10 st=01", cnt_m, st_m);
        end
        iStop = 1'b1; tick(); iStop = 1'b0;
        n_cmp++;
        if ({pause_m, busy_m, done_m, st_m} !== 5'b10000 || cnt_m !== 16'd11) begin
            n_err++;
            $display("FAIL run_stop got p/b/d/st=%b cnt=%0d exp 10000 cnt=11",
                     {pause_m, busy_m, done_m, st_m}, cnt_m);
        end
        tick();
    endtask

    task automatic test_step();
        int n_active;
        bit seen_idle;
        iStep = 1'b1; tick(); iStep = 1'b0;
        n_cmp++;
        if ({pause_m, busy_m, st_m} !== 4'b0110 || cnt_m !== 16'd0) begin
            n_err++;
            $display("FAIL step_entry got p/b/st=%b cnt=%0d exp 0110 cnt=0",
                     {pause_m, busy_m, st_m}, cnt_m);
        end
        n_active = (pause_m == 1'b0) ? 1 : 0;
        seen_idle = 0;
        for (int i = 0; i < 10 && !seen_idle; i++) begin
            tick();
            if (pause_m == 1'b0) n_active++;
            if (st_m == 2'b00) begin
                seen_idle = 1;
                n_cmp++;
                if (done_m !== 1'b1) begin
                    n_err++;
                    $display("FAIL step_done got %b exp 1", done_m);
                end
            end else if (done_m !== 1'b0) begin
                n_cmp++;
                n_err++;
                $display("FAIL step_early_done got %b exp 0", done_m);
            end
        end
        n_cmp++;
        if (!seen_idle || n_active != 4 || cnt_m !== 16'd4) begin
            n_err++;
            $display("FAIL step_len got idle=%0d active=%0d cnt=%0d exp idle=1 active=4 cnt=4",
                     seen_idle, n_active, cnt_m);
        end
        tick();
        n_cmp++;
        if (done_m !== 1'b0) begin
            n_err++;
            $display("FAIL step_done_pulse got %b exp 0", done_m);
        end
    endtask

    task automatic test_target();
        iStart = 1'b1; tick(); iStart = 1'b0;
        iTargetEn = 1'b1; iTargetState = 2'b10; iValorEstado = 2'b01;
        tick(); tick(); tick();
        iValorEstado = 2'b10;
        tick();
        n_cmp++;
        if ({pause_m, busy_m, done_m, st_m} !== 5'b10111 || cnt_m !== 16'd4) begin
            n_err++;
            $display("FAIL target_halt got p/b/d/st=%b cnt=%0d exp 10111 cnt=4",
                     {pause_m, busy_m, done_m, st_m}, cnt_m);
        end
        tick();
        n_cmp++;
        if (done_m !== 1'b0 || st_m !== 2'b11 || cnt_m !== 16'd4) begin
            n_err++;
            $display("FAIL target_hold got d=%b st=%b cnt=%0d exp d=0 st=11 cnt=4",
                     done_m, st_m, cnt_m);
        end
        iStart = 1'b1; tick(); iStart = 1'b0;
        n_cmp++;
        if ({pause_m, st_m} !== 3'b001 || cnt_m !== 16'd4) begin
            n_err++;
            $display("FAIL target_resume got p/st=%b cnt=%0d exp 001 cnt=4", {pause_m, st_m}, cnt_m);
        end
        tick(); tick(); tick();
        n_cmp++;
        if ({done_m, st_m} !== 3'b001 || cnt_m !== 16'd7) begin
            n_err++;
            $display("FAIL target_no_rehalt got d/st=%b cnt=%0d exp 001 cnt=7", {done_m, st_m}, cnt_m);
        end
    endtask

    task automatic test_priority();
        iStop = 1'b1; tick(); iStop = 1'b0; tick();
        iStop = 1'b1; iStart = 1'b1; tick(); iStop = 1'b0; iStart = 1'b0;
        n_cmp++;
        if ({pause_m, busy_m, st_m} !== 4'b1000) begin
            n_err++;
            $display("FAIL stop_beats_start got p/b/st=%b exp 1000", {pause_m, busy_m, st_m});
        end
        tick();
        iStart = 1'b1; tick(); iStart = 1'b0;
        iValorEstado = 2'b01; tick();
        iValorEstado = 2'b10; iStop = 1'b1; tick(); iStop = 1'b0;
        n_cmp++;
        if ({pause_m, done_m, st_m} !== 4'b1000) begin
            n_err++;
            $display("FAIL stop_beats_target got p/d/st=%b exp 1000", {pause_m, done_m, st_m});
        end
        tick();
        iTargetEn = 1'b0;
    endtask

    task automatic test_timeout_sat();
        bit seen_idle;
        int n_cyc;
        iRestart = 1'b1; tick(); iRestart = 1'b0; tick();
        iStart = 1'b1; tick(); iStart = 1'b0;
        seen_idle = 0;
        n_cyc = 0;
        for (int i = 0; i < 40 && !seen_idle; i++) begin
            tick();
            n_cyc++;
            if (st_t == 2'b00) seen_idle = 1;
        end
        n_cmp++;
        if (!seen_idle || n_cyc != 20 || cnt_t !== 16'd20 || done_t !== 1'b1 || pause_t !== 1'b1) begin
            n_err++;
            $display("FAIL timeout got idle=%0d cyc=%0d cnt=%0d d=%b p=%b exp idle=1 cyc=20 cnt=20 d=1 p=1",
                     seen_idle, n_cyc, cnt_t, done_t, pause_t);
        end
        n_cmp++;
        if (cnt_s !== 4'd15 || st_s !== 2'b01 || cnt_m !== 16'd20) begin
            n_err++;
            $display("FAIL saturate got cnt4=%0d st=%b cnt16=%0d exp cnt4=15 st=01 cnt16=20",
                     cnt_s, st_s, cnt_m);
        end
        tick();
        n_cmp++;
        if (done_t !== 1'b0 || st_t !== 2'b00 || cnt_s !== 4'd15) begin
            n_err++;
            $display("FAIL timeout_after got d=%b st=%b cnt4=%0d exp d=0 st=00 cnt4=15",
                     done_t, st_t, cnt_s);
        end
        iStop = 1'b1; tick(); iStop = 1'b0; tick();
    endtask

    task automatic test_async_reset();
        iStep = 1'b1; tick(); iStep = 1'b0;
        tick();
        #2;
        iRestart = 1'b1;
        iStart = 1'b1;
        #1;
        n_cmp++;
        if ({pause_m, busy_m, done_m, st_m} !== 5'b10000 || cnt_m !== 16'd0) begin
            n_err++;
            $display("FAIL async_reset got p/b/d/st=%b cnt=%0d exp 10000 cnt=0",
                     {pause_m, busy_m, done_m, st_m}, cnt_m);
        end
        tick(); tick();
        iRestart = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if ({pause_m, st_m} !== 3'b100) begin
            n_err++;
            $display("FAIL held_start_ignored got p/st=%b exp 100", {pause_m, st_m});
        end
        iStart = 1'b0; tick();
        iStart = 1'b1; tick(); iStart = 1'b0;
        n_cmp++;
        if ({pause_m, busy_m, st_m} !== 4'b0101) begin
            n_err++;
            $display("FAIL restart_start got p/b/st=%b exp 0101", {pause_m, busy_m, st_m});
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_target();
        test_priority();
        test_timeout_sat();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
